// File: rtl/gelato_l1_cache_arbiter.sv
// Purpose: round-robin arbiter sharing one L1 cache port among NUM_REQ requesters.
// Latency: request sampled in IDLE drives mem_valid next cycle; req_done/req_data are combinational on mem_done.
// Backpressure: one transaction in flight; grant is locked until mem_done, then one IDLE bubble before the next grant.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   req_valid/addr    per-requester request (addresses packed, slice i*ADDR_WIDTH +: ADDR_WIDTH)
//   req_done/data     one-hot completion pulse and shared response data
//   mem_valid/addr    registered request to the cache
//   mem_done/data     cache completion pulse and data
//   busy, grant_id    transaction in flight, current/last granted requester
//   timeout           sticky watchdog flag (built only with GELATO_L1_ARB_WATCHDOG_EN)
//
// Optional feature macro: GELATO_L1_ARB_WATCHDOG_EN
module gelato_l1_cache_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_data,
    output logic                          mem_valid,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_done,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          timeout
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       rr_next;
    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [ADDR_WIDTH-1:0] win_addr;

    // Search upward from rr_ptr, wrapping; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        win_addr  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
                win_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Explicit wrap so non-power-of-two NUM_REQ never points past the last requester.
    assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            grant_id  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state     <= ST_BUSY;
                        mem_valid <= 1'b1;
                        mem_addr  <= win_addr;
                        grant_id  <= win_id;
                    end
                end
                ST_BUSY: begin
                    if (mem_done) begin
                        state     <= ST_IDLE;
                        mem_valid <= 1'b0;
                        rr_ptr    <= rr_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion is routed straight through so the requester sees it in the mem_done cycle.
    always_comb begin
        req_done = '0;
        if (state == ST_BUSY && mem_done) begin
            req_done[grant_id] = 1'b1;
        end
    end

    assign req_data = mem_data;
    assign busy     = (state == ST_BUSY);

`ifdef GELATO_L1_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (state == ST_IDLE && win_found) begin
            wd_cnt <= '0;
        end else if (state == ST_BUSY && !mem_done && wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt + 1'b1 == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    // Always 0 for any legal TIMEOUT_CYCLES; referencing the parameter keeps it in use in this build.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_gelato_l1_cache_arbiter.sv
module tb_gelato_l1_cache_arbiter;

`ifdef GELATO_L1_ARB_WATCHDOG_EN
    localparam int WD_EN = 1;
    localparam int TO    = 8;
`else
    localparam int WD_EN = 0;
    localparam int TO    = 256;
`endif
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GW = $clog2(N);

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_done;
    logic [DW-1:0]     req_data;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic              mem_done;
    logic [DW-1:0]     mem_data;
    logic              busy;
    logic [GW-1:0]     grant_id;
    logic              timeout;

    gelato_l1_cache_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_done(req_done), .req_data(req_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data),
        .busy(busy), .grant_id(grant_id), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: one outstanding transaction, round-robin pointer, stall count.
    bit          m_busy;
    int          m_grant;
    int          m_ptr;
    logic [AW-1:0] m_addr;
    bit          m_to;
    int          m_stall;

    function automatic void model_reset();
        m_busy = 0; m_grant = 0; m_ptr = 0; m_addr = '0; m_to = 0; m_stall = 0;
    endfunction

    // What the design should do at the coming clock edge, given the current inputs.
    function automatic void model_edge();
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (req_valid[i]) begin
                    m_busy  = 1;
                    m_grant = i;
                    m_addr  = req_addr[i*AW +: AW];
                    m_stall = 0;
                    break;
                end
            end
        end else if (mem_done) begin
            m_busy = 0;
            m_ptr  = (m_grant + 1) % N;
        end else begin
            if (m_stall < TO) m_stall++;
            if (WD_EN != 0 && m_stall >= TO) m_to = 1;
        end
    endfunction

    function automatic logic [N-1:0] exp_done();
        logic [N-1:0] d;
        d = '0;
        if (m_busy && mem_done) d[m_grant] = 1'b1;
        return d;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_addr = '0; mem_done = 1'b0; mem_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; req_addr = '1; mem_done = 1'b1; mem_data = 32'h1234_5678;
        model_reset();
        #1;
        vectors++;
        if ({mem_valid, busy, timeout, grant_id} !== '0) begin
            errors++; $display("FAIL reset_ctrl: mem_valid=%b busy=%b timeout=%b grant_id=%0d, required all 0",
                               mem_valid, busy, timeout, grant_id);
        end
        vectors++;
        if (mem_addr !== '0) begin
            errors++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr);
        end
        vectors++;
        if (req_done !== '0) begin
            errors++; $display("FAIL reset_req_done: got %b, required 0", req_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = '0; req_addr = '0; mem_done = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 2'b01; req_addr[0 +: AW] = 32'h1000;
        #1;
        vectors++;
        if (mem_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency: mem_valid=%b before edge, required 0", mem_valid);
        end
        tick();
        vectors++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 || grant_id !== '0) begin
            errors++; $display("FAIL single_issue: mem_valid=%b mem_addr=%h grant=%0d, required 1 00001000 0",
                               mem_valid, mem_addr, grant_id);
        end
        tick();
        tick();
        mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (req_done !== 2'b01 || req_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_done: req_done=%b req_data=%h, required 01 deadbeef", req_done, req_data);
        end
        tick();
        mem_done = 1'b0; req_valid = '0;
        #1;
        vectors++;
        if (mem_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_after: mem_valid=%b busy=%b, required 0 0", mem_valid, busy);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_valid = 2'b11; req_addr[0 +: AW] = 32'h100; req_addr[AW +: AW] = 32'h200;
        for (int t = 0; t < 4; t++) begin
            logic [DW-1:0] d;
            logic [AW-1:0] ea;
            logic [N-1:0]  ed;
            #1;
            vectors++;
            if (busy !== 1'b0 || mem_valid !== 1'b0) begin
                errors++; $display("FAIL contention_bubble[%0d]: busy=%b mem_valid=%b, required 0 0", t, busy, mem_valid);
            end
            tick();
            ea = (t % 2 == 1) ? 32'h200 : 32'h100;
            ed = '0; ed[t % 2] = 1'b1;
            d = $urandom;
            mem_done = 1'b1; mem_data = d;
            #1;
            vectors++;
            if (grant_id !== GW'(t % 2) || mem_addr !== ea) begin
                errors++; $display("FAIL contention_grant[%0d]: grant=%0d mem_addr=%h, required %0d %h",
                                   t, grant_id, mem_addr, t % 2, ea);
            end
            vectors++;
            if (req_done !== ed || req_data !== d) begin
                errors++; $display("FAIL contention_done[%0d]: req_done=%b req_data=%h, required %b %h",
                                   t, req_done, req_data, ed, d);
            end
            tick();
            mem_done = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_addr_stable();
        do_reset();
        req_valid = 2'b01; req_addr[0 +: AW] = 32'h1234;
        tick();
        req_addr[0 +: AW] = 32'hFFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (mem_addr !== 32'h1234 || mem_valid !== 1'b1) begin
                errors++; $display("FAIL addr_stable[%0d]: mem_addr=%h mem_valid=%b, required 00001234 1", c, mem_addr, mem_valid);
            end
            tick();
        end
        mem_done = 1'b1;
        #1;
        vectors++;
        if (mem_addr !== 32'h1234 || req_done !== 2'b01) begin
            errors++; $display("FAIL addr_stable_done: mem_addr=%h req_done=%b, required 00001234 01", mem_addr, req_done);
        end
        tick();
        mem_done = 1'b0; req_valid = '0;
    endtask

    task automatic test_spurious();
        do_reset();
        mem_done = 1'b1; mem_data = 32'hABCD_0001;
        #1;
        vectors++;
        if (req_done !== '0) begin
            errors++; $display("FAIL spurious_done: req_done=%b, required 00", req_done);
        end
        tick();
        mem_done = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL spurious_state: busy=%b mem_valid=%b, required 0 0", busy, mem_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 2'b10; req_addr[AW +: AW] = 32'h2222;
        tick();
        vectors++;
        if (busy !== 1'b1 || grant_id !== GW'(1)) begin
            errors++; $display("FAIL midrst_pre: busy=%b grant=%0d, required 1 1", busy, grant_id);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({mem_valid, busy, grant_id, timeout} !== '0 || mem_addr !== '0) begin
            errors++; $display("FAIL midrst_clear: mem_valid=%b busy=%b grant=%0d timeout=%b mem_addr=%h, required all 0",
                               mem_valid, busy, grant_id, timeout, mem_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = '0; mem_done = 1'b1;
        #1;
        vectors++;
        if (req_done !== '0) begin
            errors++; $display("FAIL midrst_late_done: req_done=%b, required 00", req_done);
        end
        tick();
        mem_done = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: busy=%b, required 0", busy);
        end
        req_valid = 2'b11;
        tick();
        vectors++;
        if (busy !== 1'b1 || grant_id !== '0) begin
            errors++; $display("FAIL midrst_regrant: busy=%b grant=%0d, required 1 0", busy, grant_id);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0; req_valid = '0;
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        req_valid = 2'b01; req_addr[0 +: AW] = 32'h4000;
        tick();
        for (int c = 1; c <= 12; c++) begin
            logic e;
            #1;
            e = (WD_EN != 0) && (c - 1 >= TO);
            vectors++;
            if (timeout !== e) begin
                errors++; $display("FAIL watchdog[%0d]: timeout=%b, required %b", c, timeout, e);
            end
            tick();
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0; req_valid = '0;
        tick();
        vectors++;
        if (timeout !== 1'(WD_EN) || busy !== 1'b0) begin
            errors++; $display("FAIL watchdog_sticky: timeout=%b busy=%b, required %0d 0", timeout, busy, WD_EN);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N-1:0] ed;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*AW +: AW] = $urandom;
                end
            end
            mem_done = ($urandom_range(2, 0) == 0);
            mem_data = $urandom;
            #1;
            ed = exp_done();
            vectors++;
            if (req_done !== ed || req_data !== mem_data) begin
                errors++; $display("FAIL rand_done[%0d]: req_done=%b req_data=%h, required %b %h",
                                   cyc, req_done, req_data, ed, mem_data);
            end
            vectors++;
            if (mem_valid !== m_busy || busy !== m_busy || timeout !== m_to || grant_id !== m_grant[GW-1:0]) begin
                errors++; $display("FAIL rand_ctrl[%0d]: mem_valid=%b busy=%b timeout=%b grant=%0d, required %b %b %b %0d",
                                   cyc, mem_valid, busy, timeout, grant_id, m_busy, m_busy, m_to, m_grant);
            end
            if (m_busy) begin
                vectors++;
                if (mem_addr !== m_addr) begin
                    errors++; $display("FAIL rand_addr[%0d]: mem_addr=%h, required %h", cyc, mem_addr, m_addr);
                end
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (ed[i] && $urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
            end
        end
        req_valid = '0; mem_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_addr_stable();
        test_spurious();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
